// File: rtl/video_test_pkg.sv
// Shared definitions for the video test-pattern path: pattern IDs, sequencer
// state encoding and default pattern count.
package video_test_pkg;

    localparam int unsigned PAT_BORDER_BOX = 0;
    localparam int unsigned PAT_COLOR_BARS = 1;
    localparam int unsigned PAT_GRADIENT   = 2;
    localparam int unsigned PAT_CHECKER    = 3;

    localparam int unsigned DEFAULT_NUM_PATTERNS = 4;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, stable-sample debouncer and a
// one-cycle pulse on each accepted press (debounced 0->1).
module button_debouncer
    import video_test_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 400000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_async,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;

    // The counter holds the number of consecutive samples differing from the
    // level; the level flips on the DEBOUNCE_CYCLES-th one.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q >= CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_async;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Chooses the active test pattern; changes are applied only at the vs rising
// edge, on a debounced button press or after a frame-count dwell in auto mode.
module pattern_sequencer
    import video_test_pkg::*;
#(
    parameter  int unsigned NUM_PATTERNS    = DEFAULT_NUM_PATTERNS,
    parameter  int unsigned DWELL_FRAMES    = 120,
    parameter  int unsigned DEBOUNCE_CYCLES = 400000,
    localparam int unsigned SEL_W           = $clog2(NUM_PATTERNS)
) (
    input  logic             pixelClk,
    input  logic             reset,
    input  logic             vs,
    input  logic             btnNext,
    input  logic             autoEn,
    output logic [SEL_W-1:0] patternSel,
    output logic             frameStart,
    output logic             patternChanged,
    output logic [15:0]      frameCount
);

    localparam int unsigned DWELL_W = $clog2(DWELL_FRAMES + 1);
    localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_PATTERNS - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX  = DWELL_W'(DWELL_FRAMES);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic             last_vs_q;
    logic             frame_start_q;
    logic             frame_start_d;
    logic             auto_meta_q;
    logic             auto_sync_q;
    logic             pend_q;
    logic             pend_d;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic             changed_q;
    logic             changed_d;
    logic [15:0]      frame_count_q;
    logic [15:0]      frame_count_d;
    logic             press;
    logic             advance;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (pixelClk),
        .rst      (reset),
        .btn_async(btnNext),
        .press    (press)
    );

    always_comb begin
        frame_start_d = vs & ~last_vs_q;
        frame_count_d = frame_count_q + 16'(frame_start_q);
        state_d       = state_q;
        pend_d        = pend_q;
        dwell_d       = dwell_q;
        sel_d         = sel_q;
        changed_d     = 1'b0;
        advance       = 1'b0;
        case (state_q)
            SYNC: begin
                pend_d  = 1'b0;
                dwell_d = '0;
                if (frame_start_q) state_d = RUN;
            end
            RUN: begin
                // A press landing in the frameStart cycle joins this boundary.
                pend_d  = pend_q | press;
                advance = frame_start_q &
                          (pend_q | press | (auto_sync_q & (dwell_q == DWELL_LAST)));
                if (advance) begin
                    sel_d     = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                    changed_d = 1'b1;
                    pend_d    = 1'b0;
                    dwell_d   = '0;
                end else if (!auto_sync_q) begin
                    dwell_d = '0;
                end else if (frame_start_q && (dwell_q != DWELL_MAX)) begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            state_q       <= SYNC;
            last_vs_q     <= 1'b0;
            frame_start_q <= 1'b0;
            auto_meta_q   <= 1'b0;
            auto_sync_q   <= 1'b0;
            pend_q        <= 1'b0;
            dwell_q       <= '0;
            sel_q         <= '0;
            changed_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            last_vs_q     <= vs;
            frame_start_q <= frame_start_d;
            auto_meta_q   <= autoEn;
            auto_sync_q   <= auto_meta_q;
            pend_q        <= pend_d;
            dwell_q       <= dwell_d;
            sel_q         <= sel_d;
            changed_q     <= changed_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign patternSel     = sel_q;
    assign frameStart     = frame_start_q;
    assign patternChanged = changed_q;
    assign frameCount     = frame_count_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Scoreboard bench for pattern_sequencer: a frame-level reference model pushes
// the expected outcome of each frame boundary; a monitor checks on frameStart.
module tb_pattern_sequencer;

    localparam int unsigned NP        = 4;
    localparam int unsigned DW        = 3;
    localparam int unsigned DB        = 4;
    localparam int          FRAME_LEN = 80;

    logic        pixelClk = 1'b0;
    logic        reset    = 1'b1;
    logic        vs       = 1'b0;
    logic        btnNext  = 1'b0;
    logic        autoEn   = 1'b0;
    logic [1:0]  patternSel;
    logic        frameStart;
    logic        patternChanged;
    logic [15:0] frameCount;

    pattern_sequencer #(
        .NUM_PATTERNS   (NP),
        .DWELL_FRAMES   (DW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .pixelClk      (pixelClk),
        .reset         (reset),
        .vs            (vs),
        .btnNext       (btnNext),
        .autoEn        (autoEn),
        .patternSel    (patternSel),
        .frameStart    (frameStart),
        .patternChanged(patternChanged),
        .frameCount    (frameCount)
    );

    always #5 pixelClk = ~pixelClk;

    typedef struct {
        int old_sel;
        int new_sel;
        int changed;
        int count;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   n_pushed = 0;
    int   n_seen   = 0;

    // Frame-level reference state.
    bit   m_run          = 1'b0;
    int   m_sel          = 0;
    int   m_dwell        = 0;
    int   m_count        = 0;
    bit   m_pressed_next = 1'b0;
    bit   m_auto_next    = 1'b0;
    int   btn_cnt        = 0;

    function automatic void check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endfunction

    function automatic exp_t model_boundary(input bit pressed, input bit auto_v);
        exp_t e;
        e.old_sel = m_sel;
        e.changed = 0;
        if (!m_run) begin
            m_run = 1'b1;
        end else begin
            if (!auto_v) m_dwell = 0;
            if (pressed || (auto_v && m_dwell == DW - 1)) begin
                m_sel     = (m_sel + 1) % NP;
                m_dwell   = 0;
                e.changed = 1;
            end else if (auto_v) begin
                m_dwell++;
            end
        end
        m_count   = (m_count + 1) % 65536;
        e.new_sel = m_sel;
        e.count   = m_count;
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"},         int'(patternSel), 0);
        check({tag, "_frameStart"},  int'(frameStart), 0);
        check({tag, "_changed"},     int'(patternChanged), 0);
        check({tag, "_frameCount"},  int'(frameCount), 0);
    endtask

    task automatic drive_btn();
        btnNext = (btn_cnt > 0);
        if (btn_cnt > 0) btn_cnt--;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pixelClk); #1;
            vs = 1'b0;
            drive_btn();
        end
    endtask

    // One frame: vs high for vsw cycles, then interior activity that affects
    // the following boundary. Presses hold 10 cycles, 16 apart; the late
    // press rises so its accepted pulse coincides with the next frameStart.
    task automatic run_frame(input int vsw, input bit auto_v, input int npress,
                             input bit glitch, input bit coincide, input int rst_at);
        sb.push_back(model_boundary(m_pressed_next, m_auto_next));
        n_pushed++;
        for (int o = 0; o < FRAME_LEN; o++) begin
            @(posedge pixelClk); #1;
            vs = (o < vsw);
            if (o == 10) autoEn = auto_v;
            for (int p = 0; p < npress; p++)
                if (o == 10 + 16 * p) btn_cnt = 10;
            if (glitch && o == 62) btn_cnt = 3;
            if (coincide && o == FRAME_LEN - 5) btn_cnt = 10;
            drive_btn();
            if (rst_at != 0 && o == rst_at) begin
                reset = 1'b1;
                #1;
                check_reset_outputs("midreset");
            end
            if (rst_at != 0 && o == rst_at + 3) reset = 1'b0;
        end
        m_pressed_next = (npress > 0) || coincide;
        m_auto_next    = auto_v;
        if (rst_at != 0) begin
            m_run          = 1'b0;
            m_sel          = 0;
            m_dwell        = 0;
            m_count        = 0;
            m_pressed_next = 1'b0;
        end
    endtask

    // Monitor: on frameStart pop the expectation, check the old value in that
    // cycle and the new value, pulse and count in the following cycle.
    initial begin
        exp_t cur;
        bit   pend_chk = 1'b0;
        int   mon_sel  = 0;
        cur = '{0, 0, 0, 0};
        forever begin
            @(negedge pixelClk);
            if (reset) begin
                mon_sel  = 0;
                pend_chk = 1'b0;
            end else begin
                if (pend_chk) begin
                    check("sel_after_boundary", int'(patternSel), cur.new_sel);
                    check("changed_pulse",      int'(patternChanged), cur.changed);
                    check("frame_count",        int'(frameCount), cur.count);
                    mon_sel  = cur.new_sel;
                    pend_chk = 1'b0;
                end else begin
                    check("changed_idle", int'(patternChanged), 0);
                    check("sel_hold",     int'(patternSel), mon_sel);
                end
                if (frameStart === 1'b1) begin
                    n_seen++;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_frame_start: got frameStart=1 expected none (t=%0t)", $time);
                    end else begin
                        cur = sb.pop_front();
                        check("sel_at_frame_start", int'(patternSel), cur.old_sel);
                        pend_chk = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int vsw, av, np, gl, co;
        repeat (3) @(posedge pixelClk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Press before the first vs: ignored while in SYNC.
        btn_cnt = 10;
        idle(40);

        // No presses, auto off: five frames, pattern stays 0.
        repeat (5) run_frame(3, 1'b0, 0, 1'b0, 1'b0, 0);

        // Single press, then a glitch, then a quiet frame.
        run_frame(3, 1'b0, 1, 1'b0, 1'b0, 0);
        run_frame(3, 1'b0, 0, 1'b1, 1'b0, 0);
        run_frame(3, 1'b0, 0, 1'b0, 1'b0, 0);

        // Three presses in one frame, then single presses across the wrap.
        run_frame(3, 1'b0, 3, 1'b0, 1'b0, 0);
        repeat (4) run_frame(3, 1'b0, 1, 1'b0, 1'b0, 0);
        run_frame(3, 1'b0, 0, 1'b0, 1'b0, 0);

        // Auto mode, plus a manual press coinciding with an auto expiry.
        repeat (10) run_frame(3, 1'b1, 0, 1'b0, 1'b0, 0);
        run_frame(3, 1'b1, 0, 1'b0, 1'b0, 0);
        run_frame(3, 1'b1, 1, 1'b0, 1'b0, 0);
        repeat (4) run_frame(3, 1'b1, 0, 1'b0, 1'b0, 0);

        // Auto off mid-dwell then back on.
        run_frame(3, 1'b1, 0, 1'b0, 1'b0, 0);
        run_frame(3, 1'b0, 0, 1'b0, 1'b0, 0);
        repeat (4) run_frame(3, 1'b1, 0, 1'b0, 1'b0, 0);

        // Reset mid-dwell with a pending press.
        run_frame(3, 1'b1, 0, 1'b0, 1'b0, 0);
        run_frame(3, 1'b1, 1, 1'b0, 1'b0, 68);
        repeat (3) run_frame(3, 1'b0, 0, 1'b0, 1'b0, 0);

        // Press accepted in the frameStart cycle; single-cycle vs frames.
        run_frame(3, 1'b0, 0, 1'b0, 1'b1, 0);
        run_frame(1, 1'b0, 0, 1'b0, 1'b0, 0);
        run_frame(3, 1'b0, 0, 1'b0, 1'b0, 0);

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            vsw = $urandom_range(1, 4);
            av  = $urandom_range(0, 1);
            np  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            gl  = $urandom_range(0, 1);
            co  = ($urandom_range(0, 4) == 0) ? 1 : 0;
            run_frame(vsw, av[0], np, gl[0], co[0], 0);
        end
        run_frame(3, 1'b0, 0, 1'b0, 1'b0, 0);
        idle(5);

        check("scoreboard_drained", sb.size(), 0);
        check("frame_starts_seen",  n_seen, n_pushed);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
